// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive decoder.
// Line codes are {d_plus, d_minus}.
package usb_rx_pkg;

    localparam int          DATA_W    = 8;
    localparam int          STUFF_LEN = 6;
    localparam logic [7:0]  SYNC_BYTE = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP1,
        ST_EOP2,
        ST_ERROR
    } state_t;

    typedef enum logic [1:0] {
        LINE_SE0 = 2'b00,
        LINE_K   = 2'b01,
        LINE_J   = 2'b10,
        LINE_SE1 = 2'b11
    } line_t;

endpackage

// File: rtl/usb_nrzi_unstuff.sv
// NRZI decoder plus bit-unstuffing tracker; flags the stuffed slot and
// a 1 arriving where a stuffed 0 is mandatory.
module usb_nrzi_unstuff
    import usb_rx_pkg::*;
#(
    parameter int STUFF_LEN_P = STUFF_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_i,
    input  logic start_i,
    input  logic active_i,
    input  logic d_plus_i,
    input  logic d_minus_i,
    output logic decoded_bit_o,
    output logic bit_valid_o,
    output logic stuff_err_o
);

    localparam int CW = $clog2(STUFF_LEN_P + 1);

    logic          prev_line_q;
    logic [CW-1:0] ones_cnt_q;
    logic          se0;
    logic          stuff_slot;

    assign se0           = !d_plus_i && !d_minus_i;
    assign decoded_bit_o = (d_plus_i == prev_line_q);
    assign stuff_slot    = (ones_cnt_q == CW'(STUFF_LEN_P));
    assign bit_valid_o   = !stuff_slot;
    assign stuff_err_o   = stuff_slot && decoded_bit_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_line_q <= 1'b1;
            ones_cnt_q  <= '0;
        end else if (sample_i) begin
            if (!se0)
                prev_line_q <= d_plus_i;
            // The stuffed slot always clears the run, whether it held 0 or 1.
            if (start_i || !active_i || stuff_slot || !decoded_bit_o)
                ones_cnt_q <= '0;
            else
                ones_cnt_q <= ones_cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/usb_rx_decoder.sv
// USB receive decoder: SYNC check, byte assembly, EOP detection and
// sticky error reporting, driven by the bit timer's sample strobe.
module usb_rx_decoder
    import usb_rx_pkg::*;
#(
    parameter int DATA_W_P = DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                d_plus,
    input  logic                d_minus,
    input  logic                data_shift,
    output logic [DATA_W_P-1:0] rcv_data,
    output logic                byte_ready,
    output logic                receiving,
    output logic                eop,
    output logic                rx_error
);

    localparam int BW = $clog2(DATA_W_P);

    state_t              state_q;
    logic [DATA_W_P-1:0] shift_q;
    logic [BW-1:0]       bit_cnt_q;
    logic [DATA_W_P-1:0] rcv_data_q;
    logic                byte_ready_q;
    logic                receiving_q;
    logic                eop_q;
    logic                rx_error_q;
    logic                bad_len_q;
    logic                err_se0_q;

    line_t               line;
    logic                decoded_bit;
    logic                bit_valid;
    logic                stuff_err;
    logic                start;
    logic                active;
    logic                last_bit;
    logic                go_err;
    logic [DATA_W_P-1:0] shift_d;

    assign line     = line_t'({d_plus, d_minus});
    assign start    = data_shift && (state_q == ST_IDLE) && (line == LINE_K);
    assign active   = (state_q == ST_SYNC) || (state_q == ST_DATA);
    assign last_bit = (bit_cnt_q == BW'(DATA_W_P - 1));
    assign shift_d  = {decoded_bit, shift_q[DATA_W_P-1:1]};

    usb_nrzi_unstuff u_nrzi (
        .clk           (clk),
        .rst           (rst),
        .sample_i      (data_shift),
        .start_i       (start),
        .active_i      (active),
        .d_plus_i      (d_plus),
        .d_minus_i     (d_minus),
        .decoded_bit_o (decoded_bit),
        .bit_valid_o   (bit_valid),
        .stuff_err_o   (stuff_err)
    );

    always_comb begin
        go_err = 1'b0;
        if (data_shift) begin
            if (line == LINE_SE1) begin
                go_err = 1'b1;
            end else begin
                case (state_q)
                    ST_SYNC: go_err = (line == LINE_SE0) || stuff_err ||
                                      (bit_valid && last_bit && (shift_d[7:0] != SYNC_BYTE));
                    ST_DATA: go_err = (line != LINE_SE0) && stuff_err;
                    ST_EOP1: go_err = (line != LINE_SE0);
                    ST_EOP2: go_err = (line != LINE_J);
                    default: go_err = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            rcv_data_q   <= '0;
            byte_ready_q <= 1'b0;
            receiving_q  <= 1'b0;
            eop_q        <= 1'b0;
            rx_error_q   <= 1'b0;
            bad_len_q    <= 1'b0;
            err_se0_q    <= 1'b0;
        end else begin
            byte_ready_q <= 1'b0;
            eop_q        <= 1'b0;
            if (go_err) begin
                state_q     <= ST_ERROR;
                rx_error_q  <= 1'b1;
                receiving_q <= 1'b1;
                err_se0_q   <= 1'b0;
            end else if (data_shift) begin
                case (state_q)
                    ST_IDLE: if (line == LINE_K) begin
                        state_q     <= ST_SYNC;
                        rx_error_q  <= 1'b0;
                        receiving_q <= 1'b1;
                        bad_len_q   <= 1'b0;
                        shift_q     <= shift_d;
                        bit_cnt_q   <= BW'(1);
                    end
                    ST_SYNC: if (bit_valid) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (last_bit)
                            state_q <= ST_DATA;
                    end
                    ST_DATA: if (line == LINE_SE0) begin
                        state_q   <= ST_EOP1;
                        bad_len_q <= (bit_cnt_q != '0);
                    end else if (bit_valid) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (last_bit) begin
                            rcv_data_q   <= shift_d;
                            byte_ready_q <= 1'b1;
                        end
                    end
                    ST_EOP1: state_q <= ST_EOP2;
                    ST_EOP2: begin
                        state_q     <= ST_IDLE;
                        eop_q       <= 1'b1;
                        receiving_q <= 1'b0;
                        if (bad_len_q)
                            rx_error_q <= 1'b1;
                    end
                    ST_ERROR: begin
                        // Recovery needs an SE0 immediately followed by a J.
                        if (line == LINE_SE0) begin
                            err_se0_q <= 1'b1;
                        end else begin
                            err_se0_q <= 1'b0;
                            if ((line == LINE_J) && err_se0_q) begin
                                state_q     <= ST_IDLE;
                                receiving_q <= 1'b0;
                                bit_cnt_q   <= '0;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign rcv_data   = rcv_data_q;
    assign byte_ready = byte_ready_q;
    assign receiving  = receiving_q;
    assign eop        = eop_q;
    assign rx_error   = rx_error_q;

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Bench for usb_rx_decoder: packets are built from byte lists, bit-stuffed
// and NRZI-encoded by the bench, and decoder outputs compared to the byte list.
module tb_usb_rx_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       d_plus = 1'b1;
    logic       d_minus = 1'b0;
    logic       data_shift = 1'b0;
    logic [7:0] rcv_data;
    logic       byte_ready;
    logic       receiving;
    logic       eop;
    logic       rx_error;

    localparam logic [1:0] SYM_J = 2'b10, SYM_K = 2'b01, SYM_SE0 = 2'b00;

    int   errors = 0;
    int   checks = 0;
    int   gap = 4;
    logic lvl = 1'b1;
    int   run = 0;
    bit   stuff_en = 1'b1;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int   eop_cnt = 0;
    int   width_err = 0;
    logic br_prev = 1'b0;
    logic eop_prev = 1'b0;

    usb_rx_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .d_plus     (d_plus),
        .d_minus    (d_minus),
        .data_shift (data_shift),
        .rcv_data   (rcv_data),
        .byte_ready (byte_ready),
        .receiving  (receiving),
        .eop        (eop),
        .rx_error   (rx_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (byte_ready) begin
            got_q.push_back(rcv_data);
            if (br_prev) width_err++;
        end
        if (eop) begin
            eop_cnt++;
            if (eop_prev) width_err++;
        end
        br_prev  = byte_ready;
        eop_prev = eop;
    end

    task automatic send_sym(input logic [1:0] s);
        @(negedge clk);
        {d_plus, d_minus} = s;
        data_shift = 1'b1;
        @(negedge clk);
        data_shift = 1'b0;
        repeat (gap - 2) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        if (!b) lvl = ~lvl;
        send_sym(lvl ? SYM_J : SYM_K);
        run = b ? run + 1 : 0;
        if (stuff_en && run == 6) begin
            lvl = ~lvl;
            send_sym(lvl ? SYM_J : SYM_K);
            run = 0;
        end
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) send_bit(v[i]);
    endtask

    task automatic send_sync();
        lvl = 1'b1;
        run = 0;
        send_bits(8'h80, 8);
    endtask

    task automatic send_eop();
        send_sym(SYM_SE0);
        send_sym(SYM_SE0);
        send_sym(SYM_J);
        lvl = 1'b1;
    endtask

    task automatic clear_mon();
        got_q.delete();
        exp_q.delete();
        eop_cnt = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL reset_byte_ready got=%b exp=0", byte_ready); end
        checks++; if (receiving !== 1'b0) begin errors++; $display("FAIL reset_receiving got=%b exp=0", receiving); end
        checks++; if (eop !== 1'b0) begin errors++; $display("FAIL reset_eop got=%b exp=0", eop); end
        checks++; if (rx_error !== 1'b0) begin errors++; $display("FAIL reset_rx_error got=%b exp=0", rx_error); end
        checks++; if (rcv_data !== 8'h00) begin errors++; $display("FAIL reset_rcv_data got=%h exp=00", rcv_data); end
        @(negedge clk);
        rst = 1'b0;
        $display("reset: outputs checked");
    endtask

    task automatic test_basic();
        clear_mon();
        gap = 32;
        repeat (3) send_sym(SYM_J);
        checks++; if (receiving !== 1'b0) begin errors++; $display("FAIL idle_receiving got=%b exp=0", receiving); end
        gap = 4;
        send_sync();
        checks++; if (receiving !== 1'b1) begin errors++; $display("FAIL sync_receiving got=%b exp=1", receiving); end
        send_bits(8'hA5, 8);
        send_eop();
        repeat (3) @(negedge clk);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL basic_byte_count got=%0d exp=1", got_q.size()); end
        else begin checks++; if (got_q[0] !== 8'hA5) begin errors++; $display("FAIL basic_data got=%h exp=a5", got_q[0]); end end
        checks++; if (eop_cnt != 1) begin errors++; $display("FAIL basic_eop_count got=%0d exp=1", eop_cnt); end
        checks++; if (rx_error !== 1'b0) begin errors++; $display("FAIL basic_rx_error got=%b exp=0", rx_error); end
        checks++; if (receiving !== 1'b0) begin errors++; $display("FAIL basic_receiving_after got=%b exp=0", receiving); end
        $display("basic: bytes=%0d eop=%0d err=%b", got_q.size(), eop_cnt, rx_error);
    endtask

    task automatic test_stuff();
        clear_mon();
        send_sync();
        send_bits(8'hFF, 8);
        send_eop();
        repeat (3) @(negedge clk);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL stuff_byte_count got=%0d exp=1", got_q.size()); end
        else begin checks++; if (got_q[0] !== 8'hFF) begin errors++; $display("FAIL stuff_data got=%h exp=ff", got_q[0]); end end
        checks++; if (rx_error !== 1'b0) begin errors++; $display("FAIL stuff_rx_error got=%b exp=0", rx_error); end
        checks++; if (eop_cnt != 1) begin errors++; $display("FAIL stuff_eop_count got=%0d exp=1", eop_cnt); end
        $display("stuff: bytes=%0d err=%b", got_q.size(), rx_error);
    endtask

    task automatic test_seven_ones();
        clear_mon();
        send_sync();
        stuff_en = 1'b0;
        send_bits(8'h7F, 7);
        stuff_en = 1'b1;
        checks++; if (rx_error !== 1'b1) begin errors++; $display("FAIL ones_rx_error got=%b exp=1", rx_error); end
        checks++; if (receiving !== 1'b1) begin errors++; $display("FAIL ones_receiving got=%b exp=1", receiving); end
        send_sym(SYM_SE0);
        send_sym(SYM_J);
        lvl = 1'b1;
        checks++; if (receiving !== 1'b0) begin errors++; $display("FAIL ones_recovered got=%b exp=0", receiving); end
        checks++; if (rx_error !== 1'b1) begin errors++; $display("FAIL ones_sticky got=%b exp=1", rx_error); end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL ones_no_byte got=%0d exp=0", got_q.size()); end
        send_sync();
        checks++; if (rx_error !== 1'b0) begin errors++; $display("FAIL ones_cleared got=%b exp=0", rx_error); end
        send_bits(8'h5A, 8);
        send_eop();
        repeat (3) @(negedge clk);
        checks++; if (got_q.size() != 1 || got_q[0] !== 8'h5A) begin errors++; $display("FAIL ones_next_packet bytes=%0d exp one byte 5a", got_q.size()); end
        $display("seven_ones: err sticky then cleared, bytes=%0d", got_q.size());
    endtask

    task automatic test_bad_sync();
        clear_mon();
        lvl = 1'b1;
        run = 0;
        send_bits(8'h82, 7);
        checks++; if (rx_error !== 1'b0) begin errors++; $display("FAIL badsync_early got=%b exp=0", rx_error); end
        send_bit(1'b1);
        checks++; if (rx_error !== 1'b1) begin errors++; $display("FAIL badsync_error got=%b exp=1", rx_error); end
        send_sym(SYM_SE0);
        send_sym(SYM_J);
        lvl = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL badsync_no_byte got=%0d exp=0", got_q.size()); end
        checks++; if (eop_cnt != 0) begin errors++; $display("FAIL badsync_no_eop got=%0d exp=0", eop_cnt); end
        $display("bad_sync: err=%b", rx_error);
    endtask

    task automatic test_short();
        clear_mon();
        send_sync();
        send_bits(8'h05, 3);
        send_eop();
        repeat (3) @(negedge clk);
        checks++; if (eop_cnt != 1) begin errors++; $display("FAIL short_eop got=%0d exp=1", eop_cnt); end
        checks++; if (rx_error !== 1'b1) begin errors++; $display("FAIL short_rx_error got=%b exp=1", rx_error); end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL short_no_byte got=%0d exp=0", got_q.size()); end
        $display("short: eop=%0d err=%b", eop_cnt, rx_error);
    endtask

    task automatic test_reset_mid();
        clear_mon();
        send_sync();
        send_bits(8'h0F, 4);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (receiving !== 1'b0) begin errors++; $display("FAIL rstmid_receiving got=%b exp=0", receiving); end
        checks++; if (rcv_data !== 8'h00) begin errors++; $display("FAIL rstmid_rcv_data got=%h exp=00", rcv_data); end
        checks++; if ({byte_ready, eop, rx_error} !== 3'b000) begin errors++; $display("FAIL rstmid_pulses got=%b exp=000", {byte_ready, eop, rx_error}); end
        @(negedge clk);
        rst = 1'b0;
        {d_plus, d_minus} = SYM_J;
        send_sync();
        send_bits(8'h3C, 8);
        send_eop();
        repeat (3) @(negedge clk);
        checks++; if (got_q.size() != 1 || got_q[0] !== 8'h3C) begin errors++; $display("FAIL rstmid_next bytes=%0d exp one byte 3c", got_q.size()); end
        checks++; if (rx_error !== 1'b0) begin errors++; $display("FAIL rstmid_err got=%b exp=0", rx_error); end
        $display("reset_mid: restart bytes=%0d", got_q.size());
    endtask

    task automatic test_random();
        for (int p = 0; p < 10; p++) begin
            int n;
            clear_mon();
            gap = $urandom_range(2, 6);
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                logic [7:0] b;
                b = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
                exp_q.push_back(b);
            end
            send_sync();
            foreach (exp_q[k]) send_bits(exp_q[k], 8);
            send_eop();
            repeat (3) @(negedge clk);
            checks++;
            if (got_q != exp_q) begin
                errors++;
                $display("FAIL random_bytes pkt=%0d got_count=%0d exp_count=%0d", p, got_q.size(), exp_q.size());
            end
            checks++; if (eop_cnt != 1 || rx_error !== 1'b0) begin errors++; $display("FAIL random_eop pkt=%0d eop=%0d err=%b exp eop=1 err=0", p, eop_cnt, rx_error); end
            $display("random pkt %0d: gap=%0d bytes=%0d", p, gap, exp_q.size());
        end
        gap = 4;
    endtask

    task automatic test_back_to_back();
        clear_mon();
        gap = 2;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hC3);
        send_sync();
        send_bits(8'hFF, 8);
        send_bits(8'h00, 8);
        send_eop();
        send_sync();
        send_bits(8'hC3, 8);
        send_eop();
        repeat (3) @(negedge clk);
        checks++; if (got_q != exp_q) begin errors++; $display("FAIL b2b_bytes got_count=%0d exp_count=3", got_q.size()); end
        checks++; if (eop_cnt != 2) begin errors++; $display("FAIL b2b_eop got=%0d exp=2", eop_cnt); end
        checks++; if (width_err != 0) begin errors++; $display("FAIL pulse_width got=%0d exp=0", width_err); end
        gap = 4;
        $display("back_to_back: bytes=%0d eops=%0d", got_q.size(), eop_cnt);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stuff();
        test_seven_ones();
        test_bad_sync();
        test_short();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
